// File: rtl/mem_if_pkg.sv
// Shared data-memory port definitions: access-size codes, LSU state encoding and
// small helpers describing which accesses the memory performs natively.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_UNAL = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR   = 3'd3,
    ST_WRB  = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // The memory handles bytes anywhere, halves on even offsets, words only at offset 0.
  function automatic logic is_native(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return off == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and memory-side bus of the load/store unit.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load data extraction: picks n little-endian bytes at byte offset off out of two
// consecutive memory words and sign- or zero-extends them to 32 bits.
module lsu_load_align
  import mem_if_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = data >> {off, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: result = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the CPU data-memory port: one request in flight, non-native
// accesses split into aligned word reads or byte writes, one response per request.
module load_store_unit
  import mem_if_pkg::*;
#(
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic      clock,
  input  logic      reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_t  state;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        we_r;
  logic [2:0]  n_r;
  logic [2:0]  idx;
  logic [31:0] lo;
  logic [31:0] hi;

  logic        accept;
  logic        req_native;
  logic        req_bad;
  logic        crossing;
  logic [2:0]  idx_next;
  logic [31:0] align_result;

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign accept     = req.req_valid && req.req_ready;
  assign req_native = is_native(req.req_size, req.req_addr[1:0]);
  assign req_bad    = (req.req_size == SZ_UNAL) || (!ALLOW_UNALIGNED && !req_native);
  assign crossing   = ({1'b0, addr_r[1:0]} + n_r) > 3'd4;
  assign idx_next   = idx + 3'd1;

  lsu_load_align u_align (
    .data     ({hi, lo}),
    .off      (addr_r[1:0]),
    .size     (size_r),
    .sign_ext (signed_r),
    .result   (align_result)
  );

  // Load data is only presented during the response cycle; stores and errors read as zero.
  assign req.resp_rdata = (state == ST_RESP && !we_r && !req.resp_err) ? align_result : 32'h0;

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && accept) begin
      addr_r   <= req.req_addr;
      wdata_r  <= req.req_wdata;
      size_r   <= req.req_size;
      signed_r <= req.req_signed;
      we_r     <= req.req_we;
      n_r      <= size_bytes(req.req_size);
      hi       <= 32'h0;
    end
    if (state == ST_RD0) lo <= mem.mem_rdata;
    if (state == ST_RD1) hi <= mem.mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= 3'd0;
      req.req_ready  <= 1'b1;
      req.resp_valid <= 1'b0;
      req.resp_err   <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_re     <= 1'b0;
      mem.mem_addr   <= 32'h0;
      mem.mem_wdata  <= 32'h0;
      mem.mem_size   <= SZ_WORD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req.req_ready <= 1'b0;
            if (req_bad) begin
              state          <= ST_RESP;
              req.resp_valid <= 1'b1;
              req.resp_err   <= 1'b1;
            end else if (!req.req_we) begin
              state        <= ST_RD0;
              mem.mem_re   <= 1'b1;
              mem.mem_addr <= {req.req_addr[31:2], 2'b00};
            end else if (req_native) begin
              state         <= ST_WR;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= req.req_addr;
              mem.mem_size  <= req.req_size;
              mem.mem_wdata <= req.req_wdata;
            end else begin
              state         <= ST_WRB;
              idx           <= 3'd0;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= req.req_addr;
              mem.mem_size  <= SZ_BYTE;
              mem.mem_wdata <= {24'h0, req.req_wdata[7:0]};
            end
          end
        end
        ST_RD0: begin
          if (crossing) begin
            state        <= ST_RD1;
            mem.mem_addr <= mem.mem_addr + 32'd4;
          end else begin
            state          <= ST_RESP;
            mem.mem_re     <= 1'b0;
            mem.mem_addr   <= 32'h0;
            req.resp_valid <= 1'b1;
          end
        end
        ST_RD1: begin
          state          <= ST_RESP;
          mem.mem_re     <= 1'b0;
          mem.mem_addr   <= 32'h0;
          req.resp_valid <= 1'b1;
        end
        ST_WR: begin
          state          <= ST_RESP;
          mem.mem_we     <= 1'b0;
          mem.mem_addr   <= 32'h0;
          mem.mem_wdata  <= 32'h0;
          mem.mem_size   <= SZ_WORD;
          req.resp_valid <= 1'b1;
        end
        ST_WRB: begin
          if (idx_next == n_r) begin
            state          <= ST_RESP;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 32'h0;
            mem.mem_wdata  <= 32'h0;
            mem.mem_size   <= SZ_WORD;
            req.resp_valid <= 1'b1;
          end else begin
            idx           <= idx_next;
            mem.mem_addr  <= addr_r + {29'h0, idx_next};
            mem.mem_wdata <= {24'h0, byte_lane(wdata_r, idx_next[1:0])};
          end
        end
        ST_RESP: begin
          state          <= ST_IDLE;
          req.req_ready  <= 1'b1;
          req.resp_valid <= 1'b0;
          req.resp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-level memory
// model and a transaction-level reference of load/store results and latency.
module tb_load_store_unit;
  import mem_if_pkg::*;

  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam logic [31:0] WIN_END   = 32'h1000_0040;
  localparam int          MEM_BYTES = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  always #5 clock = ~clock;

  lsu_req_if r0();
  lsu_mem_if m0();
  lsu_req_if r1();
  lsu_mem_if m1();

  load_store_unit #(.ALLOW_UNALIGNED(1'b1)) dut0 (.clock(clock), .reset(reset), .req(r0.slave), .mem(m0.master));
  load_store_unit #(.ALLOW_UNALIGNED(1'b0)) dut1 (.clock(clock), .reset(reset), .req(r1.slave), .mem(m1.master));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a < WIN_END);
  endfunction

  function automatic logic [7:0] pre_byte(input int i);
    logic [63:0] init;
    init = 64'h8877665544332211;
    if (i < 8) return init[8*i +: 8];
    return 8'(i * 37 + 5);
  endfunction

  // Memory stand-in: combinational word read, write on posedge with lane placement by size.
  logic [7:0] smem [MEM_BYTES];

  always_comb begin
    m0.mem_rdata = 32'h0;
    if (in_win({m0.mem_addr[31:2], 2'b00}))
      m0.mem_rdata = {smem[{m0.mem_addr[5:2], 2'd3}], smem[{m0.mem_addr[5:2], 2'd2}],
                      smem[{m0.mem_addr[5:2], 2'd1}], smem[{m0.mem_addr[5:2], 2'd0}]};
  end
  assign m1.mem_rdata = 32'h0;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES; i++) smem[i] <= pre_byte(i);
    end else if (m0.mem_we && in_win(m0.mem_addr)) begin
      case (m0.mem_size)
        SZ_BYTE: smem[m0.mem_addr[5:0]] <= m0.mem_wdata[7:0];
        SZ_HALF: begin
          smem[{m0.mem_addr[5:1], 1'b0}] <= m0.mem_wdata[7:0];
          smem[{m0.mem_addr[5:1], 1'b1}] <= m0.mem_wdata[15:8];
        end
        default: begin
          smem[{m0.mem_addr[5:2], 2'd0}] <= m0.mem_wdata[7:0];
          smem[{m0.mem_addr[5:2], 2'd1}] <= m0.mem_wdata[15:8];
          smem[{m0.mem_addr[5:2], 2'd2}] <= m0.mem_wdata[23:16];
          smem[{m0.mem_addr[5:2], 2'd3}] <= m0.mem_wdata[31:24];
        end
      endcase
    end
  end

  // Bus monitor
  int re_cnt0 = 0, we_cnt0 = 0, re_cnt1 = 0, we_cnt1 = 0;
  logic [31:0] re_addr_q [$];
  logic [31:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];

  always @(negedge clock) begin
    if (m0.mem_re === 1'b1) begin re_cnt0++; re_addr_q.push_back(m0.mem_addr); end
    if (m0.mem_we === 1'b1) begin we_cnt0++; wr_addr_q.push_back(m0.mem_addr); wr_data_q.push_back(m0.mem_wdata[7:0]); end
    if (m1.mem_re === 1'b1) re_cnt1++;
    if (m1.mem_we === 1'b1) we_cnt1++;
  end

  // Transaction-level reference
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic int nbytes(input logic [1:0] s);
    return (s == SZ_BYTE) ? 1 : (s == SZ_HALF) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return in_win(a) ? ref_mem[a[5:0]] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(addr + 32'(k));
    if (sgn && n < 4 && v[8*n-1])
      for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] a;
    for (int k = 0; k < nbytes(size); k++) begin
      a = addr + 32'(k);
      if (in_win(a)) ref_mem[a[5:0]] = wdata[8*k +: 8];
    end
  endtask

  function automatic int ref_lat(input logic we, input logic [1:0] size, input logic [31:0] addr, input bit split_ok);
    int n, off;
    bit native;
    n = nbytes(size);
    off = int'(addr[1:0]);
    native = (size == SZ_BYTE) || (size == SZ_HALF && off % 2 == 0) || (size == SZ_WORD && off == 0);
    if (size == SZ_UNAL || (!split_ok && !native)) return 1;
    if (!we) return (off + n > 4) ? 3 : 2;
    return native ? 2 : n + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit sel, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clock);
    if (sel) begin
      r1.req_valid = 1'b1; r1.req_we = we; r1.req_size = size;
      r1.req_signed = sgn; r1.req_addr = addr; r1.req_wdata = wdata;
    end else begin
      r0.req_valid = 1'b1; r0.req_we = we; r0.req_size = size;
      r0.req_signed = sgn; r0.req_addr = addr; r0.req_wdata = wdata;
    end
    @(posedge clock);
    #1;
    r0.req_valid = 1'b0;
    r1.req_valid = 1'b0;
    lat = -1;
    rdata = 32'hxxxx_xxxx;
    err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if ((sel ? r1.resp_valid : r0.resp_valid) === 1'b1) begin
        lat = c;
        rdata = sel ? r1.resp_rdata : r0.resp_rdata;
        err = sel ? r1.resp_err : r0.resp_err;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, b_re, b_we, q0, got;
    logic we;
    logic [1:0] sz;
    logic sg;
    logic [31:0] ad, wd, exp_rd;
    int exp_lat;

    r0.req_valid = 1'b0; r0.req_we = 1'b0; r0.req_size = SZ_WORD; r0.req_signed = 1'b0;
    r0.req_addr = 32'h0; r0.req_wdata = 32'h0;
    r1.req_valid = 1'b0; r1.req_we = 1'b0; r1.req_size = SZ_WORD; r1.req_signed = 1'b0;
    r1.req_addr = 32'h0; r1.req_wdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pre_byte(i);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    preload = 1'b0;

    // Reset / idle state
    @(negedge clock);
    check("rst_req_ready", 32'(r0.req_ready), 32'd1);
    check("rst_resp_valid", 32'(r0.resp_valid), 32'd0);
    check("rst_resp_rdata", r0.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(r0.resp_err), 32'd0);
    check("rst_mem_we_re", {30'h0, m0.mem_we, m0.mem_re}, 32'h0);
    check("rst_mem_addr", m0.mem_addr, 32'h0);
    check("rst_mem_wdata", m0.mem_wdata, 32'h0);
    check("rst_mem_size", 32'(m0.mem_size), 32'(SZ_WORD));

    // 1. Aligned word load
    b_re = re_cnt0;
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, er, lat);
    check("t1_rdata", rd, 32'h44332211);
    check("t1_err", 32'(er), 32'd0);
    check("t1_lat", 32'(lat), 32'd2);
    check("t1_re_cycles", 32'(re_cnt0 - b_re), 32'd1);

    // 2. Byte and half loads with extension
    do_req(1'b0, 1'b0, SZ_BYTE, 1'b1, BASE + 32'd7, 32'h0, rd, er, lat);
    check("t2_byte_signed", rd, 32'hFFFFFF88);
    check("t2_byte_signed_lat", 32'(lat), 32'd2);
    do_req(1'b0, 1'b0, SZ_BYTE, 1'b0, BASE + 32'd7, 32'h0, rd, er, lat);
    check("t2_byte_unsigned", rd, 32'h00000088);
    do_req(1'b0, 1'b0, SZ_HALF, 1'b1, BASE + 32'd1, 32'h0, rd, er, lat);
    check("t2_half_off1", rd, 32'h00003322);
    check("t2_half_off1_lat", 32'(lat), 32'd2);

    // 3. Crossing word load
    q0 = re_addr_q.size();
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE + 32'd2, 32'h0, rd, er, lat);
    check("t3_re_count", 32'(re_addr_q.size() - q0), 32'd2);
    if (re_addr_q.size() >= q0 + 2) begin
      check("t3_re_addr0", re_addr_q[q0], BASE);
      check("t3_re_addr1", re_addr_q[q0 + 1], BASE + 32'd4);
    end
    check("t3_rdata", rd, 32'h66554433);
    check("t3_lat", 32'(lat), 32'd3);

    // 4. Crossing half store split into byte writes
    q0 = wr_addr_q.size();
    do_req(1'b0, 1'b1, SZ_HALF, 1'b0, BASE + 32'd3, 32'h0000BEEF, rd, er, lat);
    ref_store(BASE + 32'd3, SZ_HALF, 32'h0000BEEF);
    check("t4_lat", 32'(lat), 32'd3);
    check("t4_rdata", rd, 32'h0);
    check("t4_wr_count", 32'(wr_addr_q.size() - q0), 32'd2);
    if (wr_addr_q.size() >= q0 + 2) begin
      check("t4_wr0", {wr_addr_q[q0][23:0], wr_data_q[q0]}, {24'h000003, 8'hEF});
      check("t4_wr1", {wr_addr_q[q0 + 1][23:0], wr_data_q[q0 + 1]}, {24'h000004, 8'hBE});
    end
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, er, lat);
    check("t4_reload0", rd, 32'hEF332211);
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE + 32'd4, 32'h0, rd, er, lat);
    check("t4_reload4", rd, 32'h887766BE);

    // 5. Error responses
    b_re = re_cnt1;
    b_we = we_cnt1;
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, BASE + 32'd1, 32'h0, rd, er, lat);
    check("t5_unal_err", 32'(er), 32'd1);
    check("t5_unal_rdata", rd, 32'h0);
    check("t5_unal_lat", 32'(lat), 32'd1);
    do_req(1'b1, 1'b1, SZ_UNAL, 1'b0, BASE, 32'h12345678, rd, er, lat);
    check("t5_sz2_err", 32'(er), 32'd1);
    check("t5_sz2_rdata", rd, 32'h0);
    check("t5_sz2_lat", 32'(lat), 32'd1);
    check("t5_no_mem_access", 32'((re_cnt1 - b_re) + (we_cnt1 - b_we)), 32'd0);
    b_we = we_cnt0;
    do_req(1'b0, 1'b1, SZ_UNAL, 1'b0, BASE, 32'h12345678, rd, er, lat);
    check("t5_sz2_split_err", 32'(er), 32'd1);
    check("t5_sz2_split_lat", 32'(lat), 32'd1);
    check("t5_sz2_split_no_we", 32'(we_cnt0 - b_we), 32'd0);

    // 6. Reset during a split store
    q0 = wr_addr_q.size();
    @(negedge clock);
    r0.req_valid = 1'b1; r0.req_we = 1'b1; r0.req_size = SZ_WORD; r0.req_signed = 1'b0;
    r0.req_addr = BASE + 32'd1; r0.req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    r0.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_ready_after_reset", 32'(r0.req_ready), 32'd1);
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (r0.resp_valid === 1'b1) got++;
      @(negedge clock);
    end
    check("t6_no_resp", 32'(got), 32'd0);
    check("t6_one_write", 32'(wr_addr_q.size() - q0), 32'd1);
    ref_mem[1] = 8'h0D;
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, er, lat);
    check("t6_reload0", rd, 32'hEF330D11);
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, BASE + 32'd4, 32'h0, rd, er, lat);
    check("t6_reload4", rd, 32'h887766BE);

    // Address wrap on a crossing load at the top of the address space
    q0 = re_addr_q.size();
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, rd, er, lat);
    check("wrap_lat", 32'(lat), 32'd3);
    if (re_addr_q.size() >= q0 + 2) begin
      check("wrap_addr0", re_addr_q[q0], 32'hFFFF_FFFC);
      check("wrap_addr1", re_addr_q[q0 + 1], 32'h0000_0000);
    end else begin
      check("wrap_re_count", 32'(re_addr_q.size() - q0), 32'd2);
    end

    // Random mix against the reference
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       sz = SZ_BYTE;
        1:       sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
      sg = 1'($urandom_range(0, 1));
      ad = BASE + 32'($urandom_range(0, 59));
      wd = $urandom;
      exp_rd = we ? 32'h0 : ref_load(ad, sz, sg);
      exp_lat = ref_lat(we, sz, ad, 1'b1);
      do_req(1'b0, we, sz, sg, ad, wd, rd, er, lat);
      if (we) ref_store(ad, sz, wd);
      check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'd0);
      check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(exp_lat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
